// File: rtl/card_flip_pkg.sv
// rtl/card_flip_pkg.sv - shared constants, state encoding and card map helper
package card_flip_pkg;

  localparam int NUM_CARDS = 16;
  localparam int VAL_W     = 3;
  localparam int IDX_W     = 4;
  localparam int MAP_W     = NUM_CARDS * VAL_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHUFFLE,
    ST_WAIT_FIRST,
    ST_WAIT_SECOND,
    ST_COMPARE,
    ST_HOLD,
    ST_WIN
  } state_t;

  // Map is [0:MAP_W-1]; card i occupies [i*VAL_W +: VAL_W] with its MSB at the lower bit number.
  function automatic logic [VAL_W-1:0] card_val(input logic [0:MAP_W-1] map,
                                                input logic [IDX_W-1:0] idx);
    return map[int'(idx)*VAL_W +: VAL_W];
  endfunction

endpackage

// File: rtl/card_flip_if.sv
// rtl/card_flip_if.sv - control/status bundle between sequencer, shuffler, input logic and display
interface card_flip_if;
  import card_flip_pkg::*;

  logic                   new_game;
  logic                   shuffle_start;
  logic                   shuffle_done;
  logic [0:MAP_W-1]       shuffle_map;
  logic                   sel_valid;
  logic [IDX_W-1:0]       sel_idx;
  logic [NUM_CARDS-1:0]   face_up;
  logic [NUM_CARDS-1:0]   matched;
  logic [0:MAP_W-1]       card_map;
  logic [3:0]             pair_count;
  logic [7:0]             moves;
  logic                   busy;
  logic                   game_over;

  modport master (
    input  new_game, shuffle_done, shuffle_map, sel_valid, sel_idx,
    output shuffle_start, face_up, matched, card_map, pair_count, moves, busy, game_over
  );

  modport slave (
    output new_game, shuffle_done, shuffle_map, sel_valid, sel_idx,
    input  shuffle_start, face_up, matched, card_map, pair_count, moves, busy, game_over
  );

endinterface

// File: rtl/card_flip_ctrl_hold_timer.sv
// rtl/card_flip_ctrl_hold_timer.sv - loadable down-counter timing the mismatch display
module hold_timer #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count;

  // Stops at zero so an idle timer never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/card_flip_ctrl.sv
// rtl/card_flip_ctrl.sv - card-flip game sequencer: shuffle, select, compare, hold, win
module card_flip_ctrl
  import card_flip_pkg::*;
#(
  parameter int MISMATCH_HOLD = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  card_flip_if.master bus
);

  localparam int TW = (MISMATCH_HOLD > 1) ? $clog2(MISMATCH_HOLD) : 1;
  localparam logic [TW-1:0] HOLD_LOAD = TW'(MISMATCH_HOLD - 1);

  state_t                state;
  logic [IDX_W-1:0]      first_idx;
  logic [IDX_W-1:0]      second_idx;
  logic [NUM_CARDS-1:0]  face_up_q;
  logic [NUM_CARDS-1:0]  matched_q;
  logic [0:MAP_W-1]      card_map_q;
  logic [3:0]            pair_count_q;
  logic [7:0]            moves_q;
  logic                  shuffle_start_q;
  logic                  sel_legal;
  logic                  pair_equal;
  logic                  tmr_zero;

  assign sel_legal  = bus.sel_valid && !face_up_q[bus.sel_idx] && !matched_q[bus.sel_idx];
  assign pair_equal = (card_val(card_map_q, first_idx) == card_val(card_map_q, second_idx));

  // COMPARE loads the timer unconditionally; only a mismatch ever lets HOLD consume it.
  hold_timer #(.W(TW)) u_hold_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (state == ST_COMPARE),
    .dec        (state == ST_HOLD),
    .load_value (HOLD_LOAD),
    .zero       (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      first_idx       <= '0;
      second_idx      <= '0;
      face_up_q       <= '0;
      matched_q       <= '0;
      card_map_q      <= '0;
      pair_count_q    <= '0;
      moves_q         <= '0;
      shuffle_start_q <= 1'b0;
    end else begin
      shuffle_start_q <= 1'b0;
      if (bus.new_game && (state != ST_SHUFFLE)) begin
        shuffle_start_q <= 1'b1;
        face_up_q       <= '0;
        matched_q       <= '0;
        pair_count_q    <= '0;
        moves_q         <= '0;
        state           <= ST_SHUFFLE;
      end else begin
        case (state)
          ST_SHUFFLE: begin
            if (bus.shuffle_done) begin
              card_map_q <= bus.shuffle_map;
              state      <= ST_WAIT_FIRST;
            end
          end
          ST_WAIT_FIRST: begin
            if (sel_legal) begin
              face_up_q[bus.sel_idx] <= 1'b1;
              first_idx              <= bus.sel_idx;
              state                  <= ST_WAIT_SECOND;
            end
          end
          ST_WAIT_SECOND: begin
            if (sel_legal) begin
              face_up_q[bus.sel_idx] <= 1'b1;
              second_idx             <= bus.sel_idx;
              if (moves_q != 8'hFF) begin
                moves_q <= moves_q + 8'd1;
              end
              state <= ST_COMPARE;
            end
          end
          ST_COMPARE: begin
            if (pair_equal) begin
              matched_q[first_idx]  <= 1'b1;
              matched_q[second_idx] <= 1'b1;
              pair_count_q          <= pair_count_q + 4'd1;
              state <= (pair_count_q == 4'd7) ? ST_WIN : ST_WAIT_FIRST;
            end else begin
              state <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (tmr_zero) begin
              face_up_q[first_idx]  <= 1'b0;
              face_up_q[second_idx] <= 1'b0;
              state                 <= ST_WAIT_FIRST;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.shuffle_start = shuffle_start_q;
  assign bus.face_up       = face_up_q;
  assign bus.matched       = matched_q;
  assign bus.card_map      = card_map_q;
  assign bus.pair_count    = pair_count_q;
  assign bus.moves         = moves_q;
  assign bus.busy          = (state == ST_SHUFFLE) || (state == ST_COMPARE) || (state == ST_HOLD);
  assign bus.game_over     = (state == ST_WIN);

endmodule

// File: tb/tb_card_flip_ctrl.sv
// tb/tb_card_flip_ctrl.sv - directed and randomized checks of card_flip_ctrl against a game model
module tb_card_flip_ctrl;
  import card_flip_pkg::*;

  localparam int H = 4;
  localparam int M_IDLE = 0, M_SHUF = 1, M_SEL = 2, M_CMP = 3, M_HOLD = 4, M_WIN = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  card_flip_if bus();

  card_flip_ctrl #(.MISMATCH_HOLD(H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  int          m_mode, m_pairs, m_moves, m_first, m_second, m_hold;
  logic [15:0] m_fu, m_mt;
  logic [0:47] m_map;
  bit          m_start;
  logic [0:47] plan_map;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int val_of(input logic [0:47] m, input int i);
    return int'(m[i*3 +: 3]);
  endfunction

  // Game rules in event form: the model follows what a player would see, one clock at a time.
  task automatic model_step();
    m_start = 1'b0;
    if (reset) begin
      m_mode = M_IDLE; m_fu = '0; m_mt = '0; m_map = '0;
      m_pairs = 0; m_moves = 0; m_hold = 0; m_first = -1; m_second = 0;
    end else if (bus.new_game && m_mode != M_SHUF) begin
      m_start = 1'b1; m_fu = '0; m_mt = '0; m_pairs = 0; m_moves = 0;
      m_mode = M_SHUF; m_first = -1;
    end else begin
      case (m_mode)
        M_SHUF: if (bus.shuffle_done) begin
          m_map = bus.shuffle_map; m_mode = M_SEL; m_first = -1;
        end
        M_SEL: if (bus.sel_valid && !m_fu[bus.sel_idx] && !m_mt[bus.sel_idx]) begin
          m_fu[bus.sel_idx] = 1'b1;
          if (m_first < 0) begin
            m_first = int'(bus.sel_idx);
          end else begin
            m_second = int'(bus.sel_idx);
            if (m_moves < 255) m_moves++;
            m_mode = M_CMP;
          end
        end
        M_CMP: begin
          if (val_of(m_map, m_first) == val_of(m_map, m_second)) begin
            m_mt[m_first] = 1'b1; m_mt[m_second] = 1'b1; m_pairs++;
            m_mode = (m_pairs == 8) ? M_WIN : M_SEL;
            m_first = -1;
          end else begin
            m_hold = H; m_mode = M_HOLD;
          end
        end
        M_HOLD: begin
          m_hold--;
          if (m_hold == 0) begin
            m_fu[m_first] = 1'b0; m_fu[m_second] = 1'b0;
            m_mode = M_SEL; m_first = -1;
          end
        end
        default: begin
        end
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("shuffle_start", 64'(bus.shuffle_start), 64'(m_start));
      check("face_up", 64'(bus.face_up), 64'(m_fu));
      check("matched", 64'(bus.matched), 64'(m_mt));
      check("card_map", 64'(bus.card_map), 64'(m_map));
      check("pair_count", 64'(bus.pair_count), 64'(m_pairs));
      check("moves", 64'(bus.moves), 64'(m_moves));
      check("busy", 64'(bus.busy), 64'(m_mode == M_SHUF || m_mode == M_CMP || m_mode == M_HOLD));
      check("game_over", 64'(bus.game_over), 64'(m_mode == M_WIN));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    reset = 1'b0; bus.new_game = 1'b0; bus.sel_valid = 1'b0; bus.shuffle_done = 1'b0;
  endtask

  task automatic sel(input int i);
    bus.sel_valid = 1'b1; bus.sel_idx = 4'(i); tick();
  endtask

  task automatic ng();
    bus.new_game = 1'b1; tick();
  endtask

  task automatic done(input logic [0:47] mp);
    bus.shuffle_done = 1'b1; bus.shuffle_map = mp; tick();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    logic [0:47] rm;
    int vals[16];
    int j, t;

    for (int i = 0; i < 16; i++) plan_map[i*3 +: 3] = 3'(i >> 1);
    bus.new_game = 1'b0; bus.shuffle_done = 1'b0; bus.shuffle_map = '0;
    bus.sel_valid = 1'b0; bus.sel_idx = '0;
    chk_on = 1'b1;

    reset = 1'b1; tick();
    reset = 1'b1; tick();
    check("lit_reset_face_up", 64'(bus.face_up), 64'h0);
    check("lit_reset_busy", 64'(bus.busy), 64'h0);

    ng();
    check("lit_start_pulse", 64'(bus.shuffle_start), 64'h1);
    sel(3);
    check("lit_start_low", 64'(bus.shuffle_start), 64'h0);
    check("lit_sel_in_shuffle", 64'(bus.face_up), 64'h0);
    done(plan_map);
    check("lit_card_map", 64'(bus.card_map), 64'(plan_map));
    check("lit_wait_first_busy", 64'(bus.busy), 64'h0);

    sel(0); sel(1);
    check("lit_fu_pair", 64'(bus.face_up), 64'h0003);
    check("lit_moves1", 64'(bus.moves), 64'h1);
    idle(1);
    check("lit_matched", 64'(bus.matched), 64'h0003);
    check("lit_pairs1", 64'(bus.pair_count), 64'h1);

    sel(1);
    check("lit_sel_matched", 64'(bus.face_up), 64'h0003);
    sel(2); sel(2);
    check("lit_reselect_moves", 64'(bus.moves), 64'h1);
    sel(4);
    check("lit_mismatch_fu", 64'(bus.face_up), 64'h0017);
    check("lit_moves2", 64'(bus.moves), 64'h2);
    for (int k = 0; k < H; k++) begin
      sel(5);
      check("lit_hold_fu", 64'(bus.face_up), 64'h0017);
      check("lit_hold_busy", 64'(bus.busy), 64'h1);
    end
    idle(1);
    check("lit_hidden_fu", 64'(bus.face_up), 64'h0003);
    check("lit_hidden_matched", 64'(bus.matched), 64'h0003);
    check("lit_hidden_busy", 64'(bus.busy), 64'h0);

    ng(); done(plan_map);
    for (int p = 0; p < 8; p++) begin
      sel(2*p); sel(2*p + 1); idle(1);
    end
    check("lit_win_pairs", 64'(bus.pair_count), 64'h8);
    check("lit_win_over", 64'(bus.game_over), 64'h1);
    check("lit_win_moves", 64'(bus.moves), 64'h8);
    check("lit_win_matched", 64'(bus.matched), 64'hFFFF);
    sel(6);
    ng();
    check("lit_restart_start", 64'(bus.shuffle_start), 64'h1);
    check("lit_restart_matched", 64'(bus.matched), 64'h0);
    check("lit_restart_moves", 64'(bus.moves), 64'h0);

    done(plan_map);
    sel(0); sel(2); idle(2);
    check("lit_in_hold", 64'(bus.busy), 64'h1);
    reset = 1'b1; tick();
    check("lit_rst_fu", 64'(bus.face_up), 64'h0);
    check("lit_rst_map", 64'(bus.card_map), 64'h0);
    check("lit_rst_busy", 64'(bus.busy), 64'h0);

    ng(); done(plan_map); sel(3);
    ng();
    check("lit_ng_wait2_fu", 64'(bus.face_up), 64'h0);
    check("lit_ng_wait2_busy", 64'(bus.busy), 64'h1);
    done(plan_map);

    for (int c = 0; c < 4000; c++) begin
      t = int'($urandom_range(0, 999));
      if (t < 2) reset = 1'b1;
      if (t < 15) bus.new_game = 1'b1;
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < 16; i++) vals[i] = i >> 1;
        for (int i = 15; i > 0; i--) begin
          j = int'($urandom_range(0, i));
          t = vals[i]; vals[i] = vals[j]; vals[j] = t;
        end
        for (int i = 0; i < 16; i++) rm[i*3 +: 3] = 3'(vals[i]);
        bus.shuffle_done = 1'b1; bus.shuffle_map = rm;
      end
      bus.sel_valid = 1'($urandom_range(0, 1));
      bus.sel_idx = 4'($urandom_range(0, 15));
      tick();
    end

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/card_flip_ctrl.md
Name: card_flip_ctrl

Overview:
- Game sequencer for the card-flip board: 16 cards, 8 value pairs, 3-bit card values.
- Requests a shuffle from the random pair generator and latches the resulting 48-bit card map.
- Accepts player card selections, reveals two cards, and compares them. Marks matches, or holds a mismatch on display for a fixed time before hiding both cards.
- Counts pairs and moves, and flags game over. It sits between the input/selection logic and the random assignment datapath, and feeds the display.

Parameters:
- NUM_CARDS, 16, number of cards; fixed at 16 in this revision.
- VAL_W, 3, bits per card value.
- IDX_W, 4, card index width.
- MISMATCH_HOLD, 50000000, cycles a mismatched pair stays face up; minimum 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- new_game  in  1  pulse; start a new game.
- shuffle_start  out  1  one-cycle start pulse to the random pair generator.
- shuffle_done  in  1  one-cycle pulse from the generator; shuffle_map is valid in that cycle.
- shuffle_map  in  48  card i value at bits [i*3 +: 3]; bit 0 is the MSB end ([0:47] ordering).
- sel_valid  in  1  player selection strobe.
- sel_idx  in  4  selected card index.
- face_up  out  16  bit i = card i currently shown.
- matched  out  16  bit i = card i already paired.
- card_map  out  48  latched map, same layout as shuffle_map.
- pair_count  out  4  pairs found, 0..8.
- moves  out  8  completed two-card attempts; saturates at 255.
- busy  out  1  high in SHUFFLE, COMPARE and HOLD.
- game_over  out  1  high in WIN.

Behaviour:
- Reset: all outputs 0; state IDLE; hold timer 0. Reset mid-operation wins over every other input.
- States: IDLE, SHUFFLE, WAIT_FIRST, WAIT_SECOND, COMPARE, HOLD, WIN.
- Restart rule: new_game in any state except SHUFFLE does all of the following in one cycle:
  - asserts shuffle_start;
  - clears face_up, matched, pair_count and moves;
  - moves to SHUFFLE.
- new_game during SHUFFLE is ignored.
- SHUFFLE: wait for shuffle_done. On shuffle_done, card_map <= shuffle_map and go to WAIT_FIRST. There is no timeout.
- A selection is legal only if face_up[sel_idx]=0 and matched[sel_idx]=0. Illegal selections are ignored, with no state change.
- sel_valid is ignored in IDLE, SHUFFLE, COMPARE, HOLD and WIN.
- WAIT_FIRST: on a legal selection, face_up[idx] <= 1, latch first_idx, go to WAIT_SECOND.
- WAIT_SECOND: on a legal selection (idx != first_idx is implied by face_up), face_up[idx] <= 1, latch second_idx, moves++ (saturating), go to COMPARE.
- COMPARE (exactly one cycle): compare card_map values of first_idx and second_idx.
  - Equal: both cards' matched bits <= 1 and face_up bits stay 1; pair_count++. If pair_count was 7, go to WIN; else go to WAIT_FIRST.
  - Not equal: load timer with MISMATCH_HOLD-1 and go to HOLD.
- HOLD: decrement the timer each cycle. In the cycle the timer is 0, clear face_up for both indices and go to WAIT_FIRST. Total time in HOLD is MISMATCH_HOLD cycles.
- WIN: game_over=1 until new_game.
- Latency:
  - selection -> face_up visible: next cycle;
  - second selection -> matched/pair_count update: +2 cycles;
  - mismatch -> hidden: +2+MISMATCH_HOLD cycles.
- Simultaneous sel_valid and new_game: new_game wins.
- shuffle_done outside SHUFFLE is ignored.

Decomposition:
- Package card_flip_pkg holds:
  - constants NUM_CARDS, VAL_W, IDX_W, MAP_W = NUM_CARDS*VAL_W;
  - the state encoding (7 states, 3 bits);
  - a card_val(map, idx) extraction function.
- One sub-module, hold_timer: loadable down-counter with load, load_value and zero outputs, width derived from MISMATCH_HOLD.

Test Plan (bench uses MISMATCH_HOLD=4; map has card i value = i>>1, so pairs are (0,1),(2,3),…):
- Reset, then new_game -> shuffle_start high exactly 1 cycle. Then shuffle_done with the map -> card_map equals the map and state is WAIT_FIRST; all counters 0.
- Select 0, then 1 -> face_up=0x0003 after the 2nd selection cycle; next cycle matched=0x0003, pair_count=1, moves=1.
- Select 0, then 2 -> face_up=0x0005 and busy=1 for 4 HOLD cycles, then face_up=0x0000, matched unchanged, moves=1.
- Illegal selections: reselect the same card in WAIT_SECOND, select a matched card, and select during HOLD -> no change to face_up or moves.
- Play all 8 pairs -> pair_count=8, game_over=1, moves=8. Further sel_valid is ignored; new_game clears everything and pulses shuffle_start.
- Assert reset in HOLD, and new_game in WAIT_SECOND -> reset gives all outputs 0 and IDLE; new_game gives SHUFFLE with face_up=0.
